// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit between data and stop).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [1:0]    r_sync;
  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_data;
  logic [7:0]    r_byte;
  logic          r_dv;
  logic          r_err;
  logic          r_hold;

  state_t        w_state;
  logic [CW-1:0] w_clk_cnt;
  logic [2:0]    w_bit_idx;
  logic [7:0]    w_data;
  logic [7:0]    w_byte;
  logic          w_dv;
  logic          w_err;
  logic          w_hold;
  logic          w_rx_s;
  logic          w_cnt_done;
  logic          w_frame_ok;

`ifdef UART_RX_PARITY_EN
  logic          r_par_err;
  logic          w_par_err;
`endif

  assign w_rx_s     = r_sync[1];
  assign w_cnt_done = (r_clk_cnt == LAST_CNT);
`ifdef UART_RX_PARITY_EN
  assign w_frame_ok = w_rx_s & ~r_par_err;
`else
  assign w_frame_ok = w_rx_s;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_RX_Serial};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_byte    <= '0;
      r_dv      <= 1'b0;
      r_err     <= 1'b0;
      r_hold    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_clk_cnt <= w_clk_cnt;
      r_bit_idx <= w_bit_idx;
      r_data    <= w_data;
      r_byte    <= w_byte;
      r_dv      <= w_dv;
      r_err     <= w_err;
      r_hold    <= w_hold;
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_err;
`endif
    end
  end

  always_comb begin
    w_state   = r_state;
    w_clk_cnt = r_clk_cnt;
    w_bit_idx = r_bit_idx;
    w_data    = r_data;
    w_byte    = r_byte;
    w_dv      = 1'b0;
    w_err     = 1'b0;
    w_hold    = r_hold;
`ifdef UART_RX_PARITY_EN
    w_par_err = r_par_err;
`endif
    case (r_state)
      IDLE: begin
        w_clk_cnt = '0;
        w_bit_idx = '0;
        // After a low stop sample (break) the line must return high before a new start.
        if (w_rx_s) begin
          w_hold = 1'b0;
        end else if (!r_hold) begin
          w_state = START;
        end
      end
      START: begin
        if (r_clk_cnt == HALF_CNT) begin
          w_clk_cnt = '0;
          w_bit_idx = '0;
          w_state   = w_rx_s ? IDLE : DATA;
        end else begin
          w_clk_cnt = r_clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (w_cnt_done) begin
          w_clk_cnt         = '0;
          w_data[r_bit_idx] = w_rx_s;
          w_bit_idx         = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          end
        end else begin
          w_clk_cnt = r_clk_cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_cnt_done) begin
          w_clk_cnt = '0;
          w_par_err = (^r_data) ^ w_rx_s;
          w_state   = STOP;
        end else begin
          w_clk_cnt = r_clk_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        // Leave mid-stop-bit so a following start edge is never missed.
        if (w_cnt_done) begin
          w_clk_cnt = '0;
          w_state   = IDLE;
          w_hold    = ~w_rx_s;
          if (w_frame_ok) begin
            w_dv   = 1'b1;
            w_byte = r_data;
          end else begin
            w_err  = 1'b1;
          end
        end else begin
          w_clk_cnt = r_clk_cnt + CW'(1);
        end
      end
      default: begin
        w_state   = IDLE;
        w_clk_cnt = '0;
      end
    endcase
  end

  assign o_RX_DV   = r_dv;
  assign o_RX_Err  = r_err;
  assign o_RX_Byte = r_byte;

  a_dv_err_exclusive: assert property (@(posedge CLOCK_50) disable iff (!rst) !(r_dv && r_err));

endmodule
